// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: req/gnt/rvalid instruction prefetcher with a PC-tagged FIFO and redirect flush
module instr_prefetch_buffer #(
   parameter int DEPTH = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] boot_addr_i,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, outstanding, discard, count_nx, out_nx, discard_nx;
   logic [31:0]   fetch_addr, fetch_cur, out_pc, boot, target;
   logic          gnt, held, rsp, push, pop, credit, issue, unused_bits;

   assign unused_bits = ^{boot_addr_i[1:0], branch_addr_i[1:0]};
   assign boot = {boot_addr_i[31:2], 2'b00};
   assign target = {branch_addr_i[31:2], 2'b00};
   assign gnt = instr_req_o & instr_gnt_i;
   assign held = instr_req_o & ~instr_gnt_i;
   // a response with nothing outstanding is a protocol violation and is ignored
   assign rsp = instr_rvalid_i & (outstanding != '0);
   assign push = rsp & (discard == '0) & ~branch_i;
   assign pop = valid_o & ready_i & ~branch_i;
   assign valid_o = count != '0;
   assign rdata_o = mem[rd_ptr][32:1];
   assign err_o = valid_o & mem[rd_ptr][0];
   assign addr_o = out_pc;
   assign busy_o = (outstanding != '0) | instr_req_o;

   // next-state counters, redirect discard accounting and request credit
   always_comb begin
      out_nx = outstanding + CW'(gnt) - CW'(rsp);
      count_nx = branch_i ? '0 : count + CW'(push) - CW'(pop);
      discard_nx = branch_i ? out_nx + CW'(held) : discard - CW'(rsp & (discard != '0));
      fetch_cur = branch_i ? target : fetch_addr;
      credit = req_i & (out_nx < CW'(MAX_OUTSTANDING)) & (({1'b0, count_nx} + {1'b0, out_nx}) < (CW+1)'(DEPTH));
      issue = ~held & credit;
   end

   // control state; a held request keeps its address even across a redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_req_o <= 1'b0;
         instr_addr_o <= boot;
         fetch_addr <= boot;
         out_pc <= boot;
         count <= '0;
         outstanding <= '0;
         discard <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         instr_req_o <= held | issue;
         instr_addr_o <= issue ? fetch_cur : instr_addr_o;
         fetch_addr <= issue ? fetch_cur + 32'd4 : fetch_cur;
         out_pc <= branch_i ? target : out_pc + (pop ? 32'd4 : 32'd0);
         count <= count_nx;
         outstanding <= out_nx;
         discard <= discard_nx;
         wr_ptr <= branch_i ? '0 : wr_ptr + AW'(push);
         rd_ptr <= branch_i ? '0 : rd_ptr + AW'(pop);
      end
   end

   // word storage, data and error captured together
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {instr_rdata_i, instr_err_i};
   end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: randomized scoreboard bench with a bus slave model and directed scenarios
module tb_instr_prefetch_buffer;
   localparam int MAXO = 2;

   logic        clk = 1'b0, rst_n;
   logic [31:0] boot_addr_i, branch_addr_i, rdata_o, addr_o, instr_addr_o, instr_rdata_i;
   logic        req_i, branch_i, ready_i, valid_o, err_o, busy_o, instr_req_o;
   logic        instr_gnt_i, instr_rvalid_i, instr_err_i;

   int          n_chk = 0, n_fail = 0, pops = 0, errs = 0;
   int          gmode, rmode;
   logic        gnt_man;
   logic [31:0] rq[$], glog[$], exp_q[$];

   instr_prefetch_buffer dut (
      .clk(clk), .rst_n(rst_n), .boot_addr_i(boot_addr_i), .req_i(req_i),
      .branch_i(branch_i), .branch_addr_i(branch_addr_i), .ready_i(ready_i),
      .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
      .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fdat(input logic [31:0] a);
      return a * 32'h9E3779B1;
   endfunction

   function automatic logic ferr(input logic [31:0] a);
      return a[5:2] == 4'h2;
   endfunction

   function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", n, a, x);
      end
   endfunction

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic br(input logic [31:0] a);
      branch_i = 1'b1;
      branch_addr_i = a;
      exp_q.delete();
      exp_q.push_back({a[31:2], 2'b00});
      step();
      branch_i = 1'b0;
   endtask

   // bus slave: grants per gmode, answers in order per rmode, data derived from address
   initial forever begin
      logic [31:0] a;
      @(negedge clk);
      if (!rst_n) begin
         rq.delete();
         instr_gnt_i = 1'b0;
         instr_rvalid_i = 1'b0;
         instr_rdata_i = '0;
         instr_err_i = 1'b0;
      end else begin
         instr_gnt_i = gmode == 1 ? 1'b1 : gmode == 2 ? gnt_man : ($urandom_range(0, 2) != 0);
         if (rq.size() > 0 && (rmode == 1 || (rmode == 2 && $urandom_range(0, 1) == 1))) begin
            a = rq.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i = fdat(a);
            instr_err_i = ferr(a);
         end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i = $urandom;
            instr_err_i = 1'($urandom_range(0, 1));
         end
      end
      #1;
      if (rst_n && instr_req_o && instr_gnt_i) begin
         rq.push_back(instr_addr_o);
         glog.push_back(instr_addr_o);
      end
   end

   // monitor: bus protocol, busy tracking and scoreboard of every accepted word
   initial begin
      logic        p_req = 1'b0, p_gnt = 1'b0, g;
      logic [31:0] p_addr = '0, e;
      int          owed;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) p_req = 1'b0;
         else begin
            g = instr_req_o & instr_gnt_i;
            owed = rq.size() + int'(instr_rvalid_i) - int'(g);
            chk("busy", busy_o, (owed != 0) || instr_req_o);
            chk("max_outstanding", rq.size() <= MAXO, 1);
            chk("addr_align", instr_addr_o[1:0], 0);
            if (p_req && !p_gnt) begin
               chk("hold_req", instr_req_o, 1);
               chk("hold_addr", instr_addr_o, p_addr);
            end
            p_req = instr_req_o;
            p_gnt = instr_gnt_i;
            p_addr = instr_addr_o;
            if (valid_o && ready_i && !branch_i) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL word_unexpected: got pc %0h, expected no word", addr_o);
               end else begin
                  e = exp_q.pop_front();
                  exp_q.push_back(e + 32'd4);
                  chk("word_pc", addr_o, e);
                  chk("word_data", rdata_o, fdat(e));
                  chk("word_err", err_o, ferr(e));
                  pops++;
                  if (err_o) errs++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ta;
      rst_n = 1'b0;
      req_i = 1'b0;
      branch_i = 1'b0;
      branch_addr_i = '0;
      ready_i = 1'b1;
      boot_addr_i = 32'h83;
      gmode = 1;
      rmode = 1;
      gnt_man = 1'b0;
      exp_q.push_back(32'h80);
      step();
      step();
      chk("rst_req", instr_req_o, 0);
      chk("rst_iaddr", instr_addr_o, 32'h80);
      chk("rst_valid", valid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_pc", addr_o, 32'h80);
      rst_n = 1'b1;
      step();
      req_i = 1'b1;
      glog.delete();
      step();
      chk("lat_c1", valid_o, 0);
      step();
      chk("lat_c2", valid_o, 0);
      step();
      chk("lat_c3", valid_o, 1);
      repeat (20) step();
      chk("boot_grants", glog.size() >= 4, 1);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk("boot_seq", glog[i], 32'h80 + 32'(4 * i));

      ready_i = 1'b0;
      glog.delete();
      br(32'h1003);
      repeat (20) step();
      chk("bp_req_low", instr_req_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_grants", glog.size(), 4);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      repeat (10) step();
      chk("bp_one_more", glog.size(), 5);
      if (glog.size() == 5) chk("bp_next_addr", glog[4], 32'h1010);
      chk("bp_req_low2", instr_req_o, 0);

      gmode = 2;
      gnt_man = 1'b0;
      ready_i = 1'b1;
      br(32'h100);
      chk("hold_up", instr_req_o, 1);
      glog.delete();
      br(32'h200);
      for (int i = 0; i < 3; i++) begin
         chk("held_addr", instr_addr_o, 32'h100);
         chk("held_req", instr_req_o, 1);
         step();
      end
      gmode = 1;
      repeat (10) step();
      chk("held_grants", glog.size() >= 2, 1);
      if (glog.size() >= 2) begin
         chk("held_first", glog[0], 32'h100);
         chk("held_next", glog[1], 32'h200);
      end

      req_i = 1'b0;
      repeat (5) step();
      rmode = 0;
      ready_i = 1'b0;
      req_i = 1'b1;
      br(32'h300);
      repeat (5) step();
      chk("rd_owed", rq.size(), 2);
      rmode = 1;
      step();
      rmode = 0;
      step();
      rmode = 1;
      step();
      rmode = 0;
      repeat (5) step();
      chk("rd_buffered", valid_o, 1);
      chk("rd_owed2", rq.size(), 2);
      chk("rd_req_low", instr_req_o, 0);
      br(32'h40);
      chk("rd_flush", valid_o, 0);
      chk("rd_busy", busy_o, 1);
      rmode = 1;
      ready_i = 1'b1;
      repeat (12) step();

      req_i = 1'b0;
      repeat (5) step();
      rmode = 0;
      ready_i = 1'b0;
      req_i = 1'b1;
      br(32'h600);
      repeat (5) step();
      rmode = 1;
      step();
      rmode = 0;
      repeat (3) step();
      chk("mr_buffered", valid_o, 1);
      chk("mr_owed", rq.size(), 2);
      boot_addr_i = 32'h507;
      rst_n = 1'b0;
      #1;
      chk("mr_req", instr_req_o, 0);
      chk("mr_iaddr", instr_addr_o, 32'h504);
      chk("mr_valid", valid_o, 0);
      chk("mr_err", err_o, 0);
      chk("mr_busy", busy_o, 0);
      chk("mr_pc", addr_o, 32'h504);
      exp_q.delete();
      exp_q.push_back(32'h504);
      step();
      rst_n = 1'b1;
      gmode = 0;
      rmode = 2;
      for (int c = 0; c < 3000; c++) begin
         req_i = $urandom_range(0, 9) != 0;
         ready_i = $urandom_range(0, 9) < 7;
         if ($urandom_range(0, 24) == 0) begin
            ta = $urandom;
            branch_i = 1'b1;
            branch_addr_i = ta;
            exp_q.delete();
            exp_q.push_back({ta[31:2], 2'b00});
         end else branch_i = 1'b0;
         step();
      end
      branch_i = 1'b0;
      step();
      chk("throughput", pops > 300, 1);
      chk("errors_seen", errs > 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
